// File: rtl/inst_queue.sv
// Instruction buffer between fetch and decode: a DEPTH-entry FIFO of {pc, instr}.
// The head falls through to decode with a predecode flag that marks U-type (LUI/AUIPC) instructions.
module inst_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [31:0]              in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [31:0]              out_instr,
    output logic                     out_is_utype,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic [31:0]     instr_mem_q [DEPTH];
    logic            utype_mem_q [DEPTH];
    logic            push_s;
    logic            pop_s;

    function automatic logic is_utype_op(input logic [6:0] opcode);
        return (opcode == 7'b0110111) || (opcode == 7'b0010111);
    endfunction

    // Handshakes: in_ready deliberately ignores out_ready, so a full queue never bypasses.
    always_comb begin
        in_ready  = (count_q != FULL_C);
        out_valid = (count_q != {CW{1'b0}});
        push_s    = in_valid & in_ready;
        pop_s     = out_valid & out_ready;
    end

    assign out_pc       = pc_mem_q[rd_ptr_q];
    assign out_instr    = instr_mem_q[rd_ptr_q];
    assign out_is_utype = utype_mem_q[rd_ptr_q];
    assign count        = count_q;

    // Next-state for pointers and occupancy; flush overrides any transfer this cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is not reset; the predecode flag is captured alongside the entry.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && push_s) begin
            pc_mem_q[wr_ptr_q]    <= in_pc;
            instr_mem_q[wr_ptr_q] <= in_instr;
            utype_mem_q[wr_ptr_q] <= is_utype_op(in_instr[6:0]);
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: directed scenarios followed by random traffic,
// checked against a queue-based reference model of the FIFO rules.
module tb_inst_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic              clk = 1'b0;
    logic              rst_n, flush, in_valid, out_ready;
    logic              in_ready, out_valid, out_is_utype;
    logic [XLEN-1:0]   in_pc, out_pc;
    logic [31:0]       in_instr, out_instr;
    logic [2:0]        count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;
    ent_t model_q[$];

    inst_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .out_is_utype(out_is_utype), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic exp_utype(input logic [31:0] instr);
        logic [6:0] op;
        op = instr[6:0];
        return (op == 7'h37) || (op == 7'h17);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        int n;
        n = model_q.size();
        chk("count", 32'(count), 32'(n));
        chk("in_ready", 32'(in_ready), 32'(n != DEPTH));
        chk("out_valid", 32'(out_valid), 32'(n != 0));
        if (n != 0) begin
            chk("out_pc", out_pc, model_q[0].pc);
            chk("out_instr", out_instr, model_q[0].instr);
            chk("out_is_utype", 32'(out_is_utype), 32'(exp_utype(model_q[0].instr)));
        end
    endtask

    // One clock cycle: drive inputs, apply the edge to the model, then check after the edge.
    task automatic step(input logic rv, input logic fl, input logic iv,
                        input logic [31:0] pc, input logic [31:0] instr, input logic ordy);
        bit   do_push, do_pop;
        ent_t e;
        @(negedge clk);
        rst_n = rv; flush = fl; in_valid = iv; in_pc = pc; in_instr = instr; out_ready = ordy;
        do_push = iv && (model_q.size() != DEPTH);
        do_pop  = ordy && (model_q.size() != 0);
        @(posedge clk);
        if (!rv || fl) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                e.pc = pc; e.instr = instr;
                model_q.push_back(e);
            end
        end
        #1;
        check_state();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 3))
            0:       w[6:0] = 7'b0110111;
            1:       w[6:0] = 7'b0010111;
            2:       w[6:0] = 7'b0010011;
            default: w[6:0] = w[6:0];
        endcase
        return w;
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0;

        // Reset then idle
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Single pass-through of a LUI
        step(1'b1, 1'b0, 1'b1, 32'h100, 32'h123450B7, 1'b0);
        chk("lui_utype", 32'(out_is_utype), 32'd1);
        chk("lui_pc", out_pc, 32'h100);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("lui_drained", 32'(count), 32'd0);

        // Fill to full, hold a 5th, then pop one to admit it
        step(1'b1, 1'b0, 1'b1, 32'h0, 32'h00000013, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h4, 32'h00001097, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h8, 32'h00000013, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'hC, 32'h00001097, 1'b0);
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        step(1'b1, 1'b0, 1'b1, 32'h10, 32'h00000013, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h10, 32'h00000013, 1'b0);
        chk("full_hold", 32'(count), 32'd4);
        step(1'b1, 1'b0, 1'b1, 32'h10, 32'h00000013, 1'b1);
        chk("full_pop_no_bypass", 32'(count), 32'd3);
        step(1'b1, 1'b0, 1'b1, 32'h10, 32'h00000013, 1'b0);
        chk("fifth_accepted", 32'(count), 32'd4);

        // Drain to 2, then 10 cycles of simultaneous push and pop across the wrap
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b1, 32'h1000 + 32'(i * 4), rand_instr(), 1'b1);
            chk("pushpop_count", 32'(count), 32'd2);
        end

        // Flush beats a simultaneous push and pop
        step(1'b1, 1'b0, 1'b1, 32'h2000, 32'h00000013, 1'b0);
        chk("pre_flush_count", 32'(count), 32'd3);
        step(1'b1, 1'b1, 1'b1, 32'h2004, 32'h00000037, 1'b1);
        chk("flush_count", 32'(count), 32'd0);
        step(1'b1, 1'b0, 1'b1, 32'h200, 32'h00000013, 1'b0);
        chk("post_flush_pc", out_pc, 32'h200);

        // Reset mid-operation
        step(1'b1, 1'b0, 1'b1, 32'h204, 32'h00000017, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h208, 32'h00000013, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h20C, 32'h00000013, 1'b0);
        chk("midreset_count", 32'(count), 32'd0);
        step(1'b1, 1'b0, 1'b1, 32'h300, 32'h00000037, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h304, 32'h00000013, 1'b1);
        chk("post_reset_head", out_pc, 32'h304);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) != 0), ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 2) != 0), $urandom, rand_instr(),
                 ($urandom_range(0, 2) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
